// File: rtl/fitness_timer_ctrl.sv
// fitness_timer_ctrl: latches the switch configuration on start, loads the
// workout duration from the combinational circuit, counts it down as mm:ss
// on the 1 Hz tick, and raises a timed alarm when the workout finishes.
module fitness_timer_ctrl #(
  parameter int ALARM_TICKS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic       pause,
  input  logic       stop,
  input  logic [7:0] sw_cfg,
  input  logic [7:0] t3,
  output logic [7:0] cfg_out,
  output logic [7:0] min_left,
  output logic [5:0] sec_left,
  output logic [2:0] state,
  output logic       busy,
  output logic       alarm,
  output logic       done_pulse
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Alarm count on which DONE gives up and returns to IDLE.
  localparam logic [7:0] ALARM_LAST = 8'(ALARM_TICKS - 1);

  logic [2:0] state_reg, state_next;
  logic [7:0] cfg_reg;
  logic [7:0] min_reg;
  logic [5:0] sec_reg;
  logic [7:0] alarm_cnt_reg;
  logic       done_pulse_reg;
  logic       last_second;

  // A tick at 00:01 (or a degenerate 00:00) finishes the countdown.
  assign last_second = (min_reg == 8'd0) && (sec_reg <= 6'd1);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; stop outranks pause, which outranks tick.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_LOAD;
      end
      S_LOAD: begin
        if (stop)            state_next = S_IDLE;
        else if (t3 == 8'd0) state_next = S_DONE;
        else                 state_next = S_RUN;
      end
      S_RUN: begin
        if (stop)                     state_next = S_IDLE;
        else if (pause)               state_next = S_PAUSE;
        else if (tick && last_second) state_next = S_DONE;
      end
      S_PAUSE: begin
        if (stop)       state_next = S_IDLE;
        else if (pause) state_next = S_RUN;
      end
      S_DONE: begin
        if (stop || start)                              state_next = S_IDLE;
        else if (tick && (alarm_cnt_reg >= ALARM_LAST)) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode from the registered state.
  always_comb begin
    busy  = 1'b0;
    alarm = 1'b0;
    case (state_reg)
      S_LOAD, S_RUN, S_PAUSE: busy  = 1'b1;
      S_DONE:                 alarm = 1'b1;
      default: ;
    endcase
  end

  // Configuration latch: only an accepted start in IDLE captures the switches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 cfg_reg <= 8'd0;
    else if (state_reg == S_IDLE && start)   cfg_reg <= sw_cfg;
  end

  // mm:ss countdown; abort clears it, pause suppresses a coincident tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_reg <= 8'd0;
      sec_reg <= 6'd0;
    end else if (state_reg != S_IDLE && stop) begin
      min_reg <= 8'd0;
      sec_reg <= 6'd0;
    end else if (state_reg == S_LOAD) begin
      min_reg <= t3;
      sec_reg <= 6'd0;
    end else if (state_reg == S_RUN && !pause && tick) begin
      if (sec_reg != 6'd0) begin
        sec_reg <= sec_reg - 6'd1;
      end else if (min_reg != 8'd0) begin
        min_reg <= min_reg - 8'd1;
        sec_reg <= 6'd59;
      end
    end
  end

  // Alarm tick counter lives only while DONE persists; any exit clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      alarm_cnt_reg <= 8'd0;
    else if (state_reg == S_DONE && state_next == S_DONE) begin
      if (tick) alarm_cnt_reg <= alarm_cnt_reg + 8'd1;
    end else
      alarm_cnt_reg <= 8'd0;
  end

  // Single-cycle pulse marking entry into DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) done_pulse_reg <= 1'b0;
    else     done_pulse_reg <= (state_next == S_DONE) && (state_reg != S_DONE);
  end

  assign state      = state_reg;
  assign cfg_out    = cfg_reg;
  assign min_left   = min_reg;
  assign sec_left   = sec_reg;
  assign done_pulse = done_pulse_reg;

endmodule

// File: tb/tb_fitness_timer_ctrl.sv
// Directed bench for fitness_timer_ctrl with hand-computed expectations.
module tb_fitness_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0, start = 1'b0, pause = 1'b0, stop = 1'b0;
  logic [7:0] sw_cfg = 8'h00;
  logic [7:0] t3_val = 8'h00;
  logic [7:0] t3;
  logic [7:0] cfg_out, min_left;
  logic [5:0] sec_left;
  logic [2:0] state;
  logic       busy, alarm, done_pulse;

  int checks = 0;
  int errors = 0;

  assign t3 = t3_val;

  always #5 clk = ~clk;

  fitness_timer_ctrl #(.ALARM_TICKS(5)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .pause(pause),
    .stop(stop), .sw_cfg(sw_cfg), .t3(t3), .cfg_out(cfg_out),
    .min_left(min_left), .sec_left(sec_left), .state(state), .busy(busy),
    .alarm(alarm), .done_pulse(done_pulse)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end else
      $display("ok   %s = %0d", tag, got);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic do_tick(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1; step(); tick = 1'b0;
    end
  endtask

  initial begin
    // Reset state
    step(); step();
    chk("rst_state", state, 0);
    chk("rst_cfg", cfg_out, 0);
    chk("rst_min", min_left, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_done", done_pulse, 0);
    rst = 1'b0;
    step();

    // 1-minute workout through DONE and alarm timeout
    sw_cfg = 8'hA5; t3_val = 8'd1;
    do_start();
    chk("a_load_state", state, 1);
    chk("a_cfg", cfg_out, 8'hA5);
    chk("a_busy", busy, 1);
    step();
    chk("a_run_state", state, 2);
    chk("a_min", min_left, 1);
    chk("a_sec", sec_left, 0);
    do_tick(1);
    chk("a_1t_min", min_left, 0);
    chk("a_1t_sec", sec_left, 59);
    do_tick(58);
    chk("a_59t_sec", sec_left, 1);
    chk("a_59t_state", state, 2);
    do_tick(1);
    chk("a_end_state", state, 4);
    chk("a_end_sec", sec_left, 0);
    chk("a_end_done", done_pulse, 1);
    chk("a_end_alarm", alarm, 1);
    chk("a_end_busy", busy, 0);
    step();
    chk("a_done_once", done_pulse, 0);
    chk("a_alarm_hold", alarm, 1);
    do_tick(4);
    chk("a_4t_state", state, 4);
    do_tick(1);
    chk("a_5t_state", state, 0);
    chk("a_5t_alarm", alarm, 0);

    // Zero duration goes straight to DONE
    t3_val = 8'd0;
    do_start();
    chk("z_load", state, 1);
    step();
    chk("z_done_state", state, 4);
    chk("z_done_pulse", done_pulse, 1);
    chk("z_min", min_left, 0);
    chk("z_sec", sec_left, 0);
    stop = 1'b1; step(); stop = 1'b0;
    chk("z_stop", state, 0);

    // Pause behaviour from 02:00
    sw_cfg = 8'h12; t3_val = 8'd2;
    do_start(); step();
    chk("p_min", min_left, 2);
    do_tick(1);
    chk("p_1t_min", min_left, 1);
    chk("p_1t_sec", sec_left, 59);
    pause = 1'b1; tick = 1'b1; step(); pause = 1'b0; tick = 1'b0;
    chk("p_pause_state", state, 3);
    chk("p_pause_sec", sec_left, 59);
    do_tick(10);
    chk("p_frozen_state", state, 3);
    chk("p_frozen_sec", sec_left, 59);
    pause = 1'b1; step(); pause = 1'b0;
    chk("p_resume", state, 2);
    do_tick(1);
    chk("p_resume_sec", sec_left, 58);

    // Down to 00:10, switches ignored, then stop beats pause
    do_tick(108);
    chk("s_min", min_left, 0);
    chk("s_sec", sec_left, 10);
    sw_cfg = 8'h3C; step();
    chk("s_cfg_hold", cfg_out, 8'h12);
    stop = 1'b1; pause = 1'b1; step(); stop = 1'b0; pause = 1'b0;
    chk("s_state", state, 0);
    chk("s_sec0", sec_left, 0);
    chk("s_cfg_kept", cfg_out, 8'h12);

    // Start silences the alarm, next start re-latches switches
    t3_val = 8'd0;
    do_start(); step();
    chk("d_state", state, 4);
    do_tick(2);
    do_start();
    chk("d_silenced", state, 0);
    chk("d_alarm", alarm, 0);
    sw_cfg = 8'h5A; t3_val = 8'd2;
    do_start();
    chk("d_relatch", cfg_out, 8'h5A);
    chk("d_relatch_state", state, 1);

    // Asynchronous reset mid-run at 01:30
    step();
    do_tick(30);
    chk("r_min", min_left, 1);
    chk("r_sec", sec_left, 30);
    #2 rst = 1'b1;
    #1;
    chk("r_state", state, 0);
    chk("r_min0", min_left, 0);
    chk("r_sec0", sec_left, 0);
    chk("r_cfg0", cfg_out, 0);
    chk("r_busy0", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
